// File: rtl/rad2_seq_div.sv
// Iterative signed divider: 2W-bit dividend / W-bit divisor, one quotient bit per clock.
// Optional macro DIV_SAT_EN saturates the quotient on overflow; otherwise it wraps.
module rad2_seq_div #(
    parameter int W = 8
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [2*W-1:0] dvdnd_i,
    input  logic [W-1:0]   dvsr_i,
    output logic [W-1:0]   quot_o,
    output logic [W-1:0]   rem_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           ovf_o,
    output logic           dbz_o,
    output logic [1:0]     state_o
);
    // Handshake: start_i is sampled only in IDLE; busy_o is high in CALC and FIXUP;
    // done_o pulses for one cycle in DONE; results hold until the next accepted start.
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    localparam int CW = $clog2(2*W) + 1;

    state_t         state;
    logic           sn;
    logic           sd;
    logic           zd;
    logic [2*W-1:0] q;
    logic [W-1:0]   mag_d;
    logic [W-1:0]   pr;
    logic [W-1:0]   lo;
    logic [CW-1:0]  cnt;

    logic [2*W-1:0] mag_n_in;
    logic [W-1:0]   mag_d_in;
    logic [W:0]     pr_sh;
    logic           fits;
    logic [W-1:0]   pr_sub;
    logic [2*W-1:0] q_s;
    logic [W-1:0]   r_s;
    logic           q_ovf;
    logic [W-1:0]   q_out;

    assign state_o  = state;
    assign mag_n_in = dvdnd_i[2*W-1] ? -dvdnd_i : dvdnd_i;
    assign mag_d_in = dvsr_i[W-1] ? -dvsr_i : dvsr_i;

    // The remainder after subtraction is below |divisor|, so W-bit modular subtraction is exact.
    assign pr_sh  = {pr, q[2*W-1]};
    assign fits   = pr_sh >= {1'b0, mag_d};
    assign pr_sub = pr_sh[W-1:0] - mag_d;

    assign q_s   = (sn ^ sd) ? -q : q;
    assign r_s   = sn ? -pr : pr;
    assign q_ovf = (|q_s[2*W-1:W-1]) && !(&q_s[2*W-1:W-1]);

`ifdef DIV_SAT_EN
    assign q_out = !q_ovf ? q_s[W-1:0]
                 : (sn ^ sd) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
    assign q_out = q_s[W-1:0];
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= IDLE;
            sn     <= 1'b0;
            sd     <= 1'b0;
            zd     <= 1'b0;
            q      <= '0;
            mag_d  <= '0;
            pr     <= '0;
            lo     <= '0;
            cnt    <= '0;
            quot_o <= '0;
            rem_o  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            ovf_o  <= 1'b0;
            dbz_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        sn     <= dvdnd_i[2*W-1];
                        sd     <= dvsr_i[W-1];
                        zd     <= (dvsr_i == '0);
                        q      <= mag_n_in;
                        mag_d  <= mag_d_in;
                        pr     <= '0;
                        lo     <= dvdnd_i[W-1:0];
                        cnt    <= '0;
                        quot_o <= '0;
                        rem_o  <= '0;
                        ovf_o  <= 1'b0;
                        dbz_o  <= 1'b0;
                        busy_o <= 1'b1;
                        state  <= (dvsr_i == '0) ? FIXUP : CALC;
                    end
                end
                CALC: begin
                    pr  <= fits ? pr_sub : pr_sh[W-1:0];
                    q   <= {q[2*W-2:0], fits};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(2*W-1)) begin
                        state <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (zd) begin
                        quot_o <= '0;
                        rem_o  <= lo;
                        ovf_o  <= 1'b0;
                        dbz_o  <= 1'b1;
                    end else begin
                        quot_o <= q_out;
                        rem_o  <= r_s;
                        ovf_o  <= q_ovf;
                        dbz_o  <= 1'b0;
                    end
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rad2_seq_div.sv
// Self-checking bench for rad2_seq_div: directed table, hand-written corner sequences,
// and random operands checked against an arithmetic reference model.
module tb_rad2_seq_div;
  localparam int W = 8;
`ifdef DIV_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef logic [2*W+1:0] res_t;  // {quot, rem, ovf, dbz}

  typedef struct {
    logic [2*W-1:0] n;
    logic [W-1:0]   d;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           ovf;
    logic           dbz;
  } vec_t;

  logic           clk;
  logic           rst;
  logic           start;
  logic [2*W-1:0] dvdnd;
  logic [W-1:0]   dvsr;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;
  logic           busy;
  logic           done;
  logic           ovf;
  logic           dbz;
  logic [1:0]     state;

  int   errors = 0;
  int   checks = 0;
  res_t exp_q[$];
  vec_t tbl[12];

  rad2_seq_div #(.W(W)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .dvdnd_i(dvdnd), .dvsr_i(dvsr),
    .quot_o(quot), .rem_o(rem), .busy_o(busy), .done_o(done), .ovf_o(ovf),
    .dbz_o(dbz), .state_o(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: plain signed integer division, truncating toward zero.
  function automatic res_t model(input logic [2*W-1:0] n, input logic [W-1:0] d);
    longint a, b, qq, rr;
    logic   o;
    logic [W-1:0] qv;
    a = longint'($signed(n));
    b = longint'($signed(d));
    if (b == 0) return {{W{1'b0}}, n[W-1:0], 1'b0, 1'b1};
    qq = a / b;
    rr = a % b;
    o  = (qq > (2**(W-1)) - 1) || (qq < -(2**(W-1)));
    qv = qq[W-1:0];
    if (o && SAT) qv = (qq > 0) ? W'((2**(W-1)) - 1) : W'(2**(W-1));
    return {qv, rr[W-1:0], o, 1'b0};
  endfunction

  // driver: present operands, let the next edge accept them
  task automatic start_op(input logic [2*W-1:0] n, input logic [W-1:0] d, input bit hold);
    dvdnd = n;
    dvsr  = d;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    dvdnd = 16'($urandom);
    dvsr  = 8'($urandom);
  endtask

  // called at the sample right after the accepting edge
  task automatic wait_done(output int lat, output int busy_n);
    lat = 0;
    busy_n = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic check_res(input string nm);
    res_t e;
    if (exp_q.size() == 0) begin
      chk({nm, " scoreboard"}, 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({nm, " done"}, 32'(done), 32'd1);
    chk({nm, " quot"}, 32'(quot), 32'(e[2*W+1:W+2]));
    chk({nm, " rem"},  32'(rem),  32'(e[W+1:2]));
    chk({nm, " ovf"},  32'(ovf),  32'(e[1]));
    chk({nm, " dbz"},  32'(dbz),  32'(e[0]));
    chk({nm, " busy@done"}, 32'(busy), 32'd0);
  endtask

  task automatic run_div(input string nm, input logic [2*W-1:0] n, input logic [W-1:0] d,
                         input res_t e, input bit hold);
    int lat, bn, want;
    want = (d == '0) ? 1 : 2*W + 1;
    exp_q.push_back(e);
    start_op(n, d, hold);
    wait_done(lat, bn);
    chk({nm, " latency"}, 32'(lat), 32'(want));
    chk({nm, " busy cycles"}, 32'(bn), 32'(want));
    check_res(nm);
    @(posedge clk); #1;
    chk({nm, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat, bn, dones;
    logic [2*W-1:0] n;
    logic [W-1:0]   d;

    tbl[0]  = '{16'(-40),    8'd8,     8'hFB, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{16'd100,     8'(-7),   8'hF2, 8'h02, 1'b0, 1'b0};
    tbl[2]  = '{16'(-100),   8'd7,     8'hF2, 8'hFE, 1'b0, 1'b0};
    tbl[3]  = '{16'(-100),   8'(-7),   8'h0E, 8'hFE, 1'b0, 1'b0};
    tbl[4]  = '{16'd1000,    8'd3,     SAT ? 8'h7F : 8'h4D, 8'h01, 1'b1, 1'b0};
    tbl[5]  = '{16'h8000,    8'hFF,    SAT ? 8'h7F : 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{16'd55,      8'd0,     8'h00, 8'h37, 1'b0, 1'b1};
    tbl[7]  = '{16'h7FFF,    8'd127,   SAT ? 8'h7F : 8'h02, 8'h01, 1'b1, 1'b0};
    tbl[8]  = '{16'h8000,    8'd127,   SAT ? 8'h80 : 8'hFE, 8'hFE, 1'b1, 1'b0};
    tbl[9]  = '{16'd127,     8'h80,    8'h00, 8'h7F, 1'b0, 1'b0};
    tbl[10] = '{16'(-16384), 8'h80,    SAT ? 8'h7F : 8'h80, 8'h00, 1'b1, 1'b0};
    tbl[11] = '{16'(-16384), 8'd128,   8'h80, 8'h00, 1'b0, 1'b0};
    tbl[11].d = 8'h80;
    tbl[11].n = 16'd16384;

    rst = 1'b1;
    start = 1'b0;
    dvdnd = '0;
    dvsr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset quot", 32'(quot), 32'd0);
    chk("reset rem", 32'(rem), 32'd0);
    chk("reset flags", 32'({busy, done, ovf, dbz}), 32'd0);
    chk("reset state", 32'(state), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tbl[i])
      run_div($sformatf("tbl%0d", i), tbl[i].n, tbl[i].d,
              {tbl[i].q, tbl[i].r, tbl[i].ovf, tbl[i].dbz}, 1'b0);

    // divide by zero with start held high while busy: a single done
    run_div("dbz hold", 16'd55, 8'd0, {8'h00, 8'h37, 1'b0, 1'b1}, 1'b1);
    dones = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("dbz hold extra done", 32'(dones), 32'd0);

    // asynchronous reset mid-operation
    start_op(16'd200, 8'd9, 1'b0);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst state", 32'(state), 32'd0);
    chk("midrst outputs", 32'({quot, rem, ovf, dbz}), 32'd0);
    @(posedge clk); #3 rst = 1'b0;
    dones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("midrst no done", 32'(dones), 32'd0);
    run_div("min/min", 16'hFF80, 8'h80, {8'h01, 8'h00, 1'b0, 1'b0}, 1'b0);

    // back-to-back: start in DONE ignored, accepted in the following IDLE
    exp_q.push_back({8'hF2, 8'h02, 1'b0, 1'b0});
    start_op(16'd100, 8'(-7), 1'b0);
    wait_done(lat, bn);
    check_res("b2b first");
    dvdnd = 16'(-100);
    dvsr  = 8'(-7);
    start = 1'b1;
    @(posedge clk); #1;
    chk("b2b ignored busy", 32'(busy), 32'd0);
    chk("b2b held quot", 32'(quot), 32'hF2);
    chk("b2b held rem", 32'(rem), 32'h02);
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b accepted busy", 32'(busy), 32'd1);
    chk("b2b cleared", 32'({quot, rem}), 32'd0);
    exp_q.push_back({8'h0E, 8'hFE, 1'b0, 1'b0});
    wait_done(lat, bn);
    chk("b2b latency", 32'(lat), 32'(2*W + 1));
    check_res("b2b second");
    @(posedge clk); #1;

    // random operands against the model
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: begin n = 16'($urandom); d = 8'($urandom); end
        1: begin
          n = 16'($signed(16'($urandom)) >>> $urandom_range(1, 9));
          d = 8'($urandom);
        end
        2: begin n = 16'($urandom); d = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'h80; end
        default: begin
          n = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h7FFF;
          d = ($urandom_range(0, 1) == 0) ? 8'h01 : 8'hFF;
        end
      endcase
      run_div($sformatf("rnd%0d", k), n, d, model(n, d), 1'b0);
    end

    chk("scoreboard empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
